mw_pipe_reg: RTL and testbench

MW_PIPE_REG -- requirements
Module: mw_pipe_reg

---
 rtl/mw_pipe_reg.sv | 154 +++++++++++++++
 tb/tb_mw_pipe_reg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mw_pipe_reg.sv
// Memory-to-writeback pipeline register: two-entry elastic buffer (head + skid)
// with forwarding taps and a saturating backpressure counter.
module mw_pipe_reg #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RA_W   = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mtr,
  input  logic              in_rw,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mtr,
  output logic              out_rw,
  output logic [RA_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem,
  output logic [DATA_W-1:0] out_wb_data,
  output logic              fwd_en,
  output logic [RA_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, state_nx;
  logic   armed;

  logic              h_mtr, h_rw, s_mtr, s_rw;
  logic [RA_W-1:0]   h_rd, s_rd;
  logic [DATA_W-1:0] h_alu, h_mem, s_alu, s_mem;

  logic in_fire, out_fire;
  logic ld_head_in, ld_head_skid, ld_skid;

  // armed keeps in_ready low through reset and releases it on the first edge after
  assign in_ready  = armed && (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_nx     = state;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nx   = ONE;
          ld_head_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          ld_head_in = 1'b1;
        end else if (in_fire) begin
          state_nx = TWO;
          ld_skid  = 1'b1;
        end else if (out_fire) begin
          state_nx = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_nx     = ONE;
          ld_head_skid = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx     = EMPTY;
      ld_head_in   = 1'b0;
      ld_head_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_mtr <= 1'b0;
      h_rw  <= 1'b0;
      h_rd  <= '0;
      h_alu <= '0;
      h_mem <= '0;
    end else if (ld_head_in) begin
      h_mtr <= in_mtr;
      h_rw  <= in_rw;
      h_rd  <= in_rd;
      h_alu <= in_alu;
      h_mem <= in_mem;
    end else if (ld_head_skid) begin
      h_mtr <= s_mtr;
      h_rw  <= s_rw;
      h_rd  <= s_rd;
      h_alu <= s_alu;
      h_mem <= s_mem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_mtr <= 1'b0;
      s_rw  <= 1'b0;
      s_rd  <= '0;
      s_alu <= '0;
      s_mem <= '0;
    end else if (ld_skid) begin
      s_mtr <= in_mtr;
      s_rw  <= in_rw;
      s_rd  <= in_rd;
      s_alu <= in_alu;
      s_mem <= in_mem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_mtr     = h_mtr;
  assign out_rw      = h_rw;
  assign out_rd      = h_rd;
  assign out_alu     = h_alu;
  assign out_mem     = h_mem;
  assign out_wb_data = h_mtr ? h_mem : h_alu;
  assign fwd_en      = out_valid && h_rw;
  assign fwd_rd      = h_rd;
  assign fwd_data    = out_wb_data;

endmodule

// File: tb/tb_mw_pipe_reg.sv
// Bench for mw_pipe_reg: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mw_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mtr = 1'b0;
  logic        in_rw = 1'b0;
  logic [2:0]  in_rd = '0;
  logic [15:0] in_alu = '0;
  logic [15:0] in_mem = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_mtr, out_rw, fwd_en;
  logic [2:0]  out_rd, fwd_rd;
  logic [15:0] out_alu, out_mem, out_wb_data, fwd_data, stall_cnt;

  logic        s_in_ready, s_out_valid, s_out_mtr, s_out_rw, s_fwd_en;
  logic [2:0]  s_out_rd, s_fwd_rd;
  logic [15:0] s_out_alu, s_out_mem, s_out_wb_data, s_fwd_data;
  logic [2:0]  s_stall_cnt;

  always #5 clk = ~clk;

  mw_pipe_reg u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mtr(in_mtr), .in_rw(in_rw),
    .in_rd(in_rd), .in_alu(in_alu), .in_mem(in_mem),
    .out_valid(out_valid), .out_ready(out_ready), .out_mtr(out_mtr), .out_rw(out_rw),
    .out_rd(out_rd), .out_alu(out_alu), .out_mem(out_mem), .out_wb_data(out_wb_data),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .stall_cnt(stall_cnt)
  );

  mw_pipe_reg #(.CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_mtr(in_mtr), .in_rw(in_rw),
    .in_rd(in_rd), .in_alu(in_alu), .in_mem(in_mem),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_mtr(s_out_mtr), .out_rw(s_out_rw),
    .out_rd(s_out_rd), .out_alu(s_out_alu), .out_mem(s_out_mem), .out_wb_data(s_out_wb_data),
    .fwd_en(s_fwd_en), .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data), .stall_cnt(s_stall_cnt)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: FIFO of capacity two, counted at the level of transactions
  typedef struct packed {
    logic        mtr;
    logic        rw;
    logic [2:0]  rd;
    logic [15:0] alu;
    logic [15:0] mem;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_stall  = 0;
  int unsigned m_stall3 = 0;
  bit          m_arm    = 0;
  bit          m_ir, m_ov;
  ent_t        m_new;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_stall  = 0;
        m_stall3 = 0;
        m_arm    = 0;
      end else begin
        m_ir  = m_arm && (mq.size() < 2);
        m_ov  = (mq.size() > 0);
        m_new = '{mtr: in_mtr, rw: in_rw, rd: in_rd, alu: in_alu, mem: in_mem};
        if (m_ov && !out_ready && !flush) begin
          if (m_stall < 65535) m_stall++;
          if (m_stall3 < 7) m_stall3++;
        end
        if (flush) mq.delete();
        else begin
          if (m_ov && out_ready) void'(mq.pop_front());
          if (in_valid && m_ir) mq.push_back(m_new);
        end
        m_arm = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready",  64'(in_ready),  64'(m_arm && (mq.size() < 2)));
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("stall3",    64'(s_stall_cnt), 64'(m_stall3));
      if (mq.size() > 0) begin
        chk("fwd_en",   64'(fwd_en),   64'(mq[0].rw));
        chk("out_rd",   64'(out_rd),   64'(mq[0].rd));
        chk("out_alu",  64'(out_alu),  64'(mq[0].alu));
        chk("out_mem",  64'(out_mem),  64'(mq[0].mem));
        chk("out_mtr",  64'(out_mtr),  64'(mq[0].mtr));
        chk("wb_data",  64'(out_wb_data), 64'(mq[0].mtr ? mq[0].mem : mq[0].alu));
        chk("fwd_data", 64'(fwd_data), 64'(mq[0].mtr ? mq[0].mem : mq[0].alu));
        chk("fwd_rd",   64'(fwd_rd),   64'(mq[0].rd));
      end else begin
        chk("fwd_en_idle", 64'(fwd_en), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic mtr, input logic rw, input logic [2:0] rd,
                      input logic [15:0] alu, input logic [15:0] mem);
    in_valid = v;
    in_mtr   = mtr;
    in_rw    = rw;
    in_rd    = rd;
    in_alu   = alu;
    in_mem   = mem;
  endtask

  initial begin
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_stall", 64'(stall_cnt), 64'(0));

    // pass-through
    out_ready = 1'b1;
    send(1, 1, 1, 3'd5, 16'h1234, 16'hBEEF);
    tick();
    in_valid = 1'b0;
    chk("pt_valid", 64'(out_valid), 64'(1));
    chk("pt_wb", 64'(out_wb_data), 64'hBEEF);
    chk("pt_fwd_en", 64'(fwd_en), 64'(1));
    chk("pt_fwd_rd", 64'(fwd_rd), 64'(5));
    tick();
    chk("pt_drain", 64'(out_valid), 64'(0));
    chk("pt_fwd_off", 64'(fwd_en), 64'(0));

    // backpressure: A then B held, released in order
    out_ready = 1'b0;
    send(1, 0, 1, 3'd1, 16'h0001, 16'h0000);
    tick();
    send(1, 0, 1, 3'd2, 16'h0002, 16'h0000);
    tick();
    in_valid = 1'b0;
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_stall1", 64'(stall_cnt), 64'(1));
    tick();
    tick();
    chk("bp_stall3", 64'(stall_cnt), 64'(3));
    chk("bp_hold_a", 64'(out_alu), 64'h0001);
    out_ready = 1'b1;
    tick();
    chk("bp_b", 64'(out_alu), 64'h0002);
    chk("bp_b_valid", 64'(out_valid), 64'(1));
    chk("bp_stall_keep", 64'(stall_cnt), 64'(3));
    tick();
    chk("bp_drain", 64'(out_valid), 64'(0));

    // full throughput
    for (int i = 0; i < 8; i++) begin
      send(1, 0, 1, 3'(i), 16'h0100 + 16'(i), 16'h0000);
      tick();
      chk("ft_valid", 64'(out_valid), 64'(1));
      chk("ft_ready", 64'(in_ready), 64'(1));
      chk("ft_alu", 64'(out_alu), 64'h0100 + 64'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("ft_drain", 64'(out_valid), 64'(0));

    // flush from TWO
    out_ready = 1'b0;
    send(1, 0, 0, 3'd3, 16'h0AAA, 16'h0000);
    tick();
    send(1, 1, 0, 3'd4, 16'h0BBB, 16'h0CCC);
    tick();
    in_valid = 1'b0;
    chk("fl_two", 64'(in_ready), 64'(0));
    chk("fl_stall_pre", 64'(stall_cnt), 64'(4));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'(0));
    chk("fl_ready", 64'(in_ready), 64'(1));
    chk("fl_stall", 64'(stall_cnt), 64'(4));

    // flush discards an entry accepted in the same cycle
    send(1, 0, 1, 3'd6, 16'h0DDD, 16'h0000);
    tick();
    send(1, 0, 1, 3'd7, 16'h0EEE, 16'h0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_same_valid", 64'(out_valid), 64'(0));
    chk("fl_same_stall", 64'(stall_cnt), 64'(4));

    // saturation of the 3-bit counter
    send(1, 0, 1, 3'd1, 16'h0F0F, 16'h0000);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_7", 64'(s_stall_cnt), 64'(7));
    chk("sat_wide", 64'(stall_cnt), 64'(14));
    tick();
    tick();
    chk("sat_hold", 64'(s_stall_cnt), 64'(7));

    // async reset while in TWO, between edges
    send(1, 1, 1, 3'd2, 16'h1111, 16'h2222);
    tick();
    in_valid = 1'b0;
    chk("rs_two", 64'(in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_valid", 64'(out_valid), 64'(0));
    chk("rs_fields", {out_mtr, out_rw, out_rd, out_alu, out_mem}, 64'(0));
    chk("rs_wb", 64'(out_wb_data), 64'(0));
    chk("rs_stall", 64'(stall_cnt), 64'(0));
    chk("rs_stall3", 64'(s_stall_cnt), 64'(0));
    chk("rs_ready", 64'(in_ready), 64'(0));
    chk("rs_fwd", 64'(fwd_en), 64'(0));
    tick();
    chk("rs_held", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("rs_release", 64'(in_ready), 64'(1));
    chk("rs_empty", 64'(out_valid), 64'(0));

    out_ready = 1'b1;
    send(1, 0, 1, 3'd3, 16'h5A5A, 16'h0000);
    tick();
    in_valid = 1'b0;
    chk("post_rs_pt", 64'(out_wb_data), 64'h5A5A);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
